jtkiwi_shr_sub: RTL
===================

JTKIWI_SHR_SUB -- requirements
Module: jtkiwi_shr_sub

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous reset, active-high.
REQ-003 SHALL have: cen  in  1  sub-CPU clock enable; FSM advances on every clk, wait_n is sampled by the CPU on cen.
REQ-004 SHALL have: snd_rstn  in  1  sub-CPU reset from main; low acts as reset.
REQ-005 SHALL have: A  in  16  sub-CPU address; mreq_n, rfsh_n, rd_n, wr_n  in  1 each  Z80 strobes; cpu_dout  in  8  CPU write data.
REQ-006 SHALL have: cpu_din  out  8  read data to CPU; wait_n  out  1  CPU wait; shr_hit  out  1  decoded window access.
REQ-007 SHALL have: shr_cs  out  1; shr_addr  out  13; shr_din  out  8; sub_rnw  out  1  request bus toward main's shared RAM.
REQ-008 SHALL have: shr_dout  in  8  shared-RAM read port, one clock latency; mshramen  in  1  main owns RAM.
REQ-009 SHALL have parameter: WIN, default 3'b110, value of A[15:13] selecting the shared window (C000-DFFF).

Function
REQ-010 shr_hit SHALL be ~mreq_n & rfsh_n & (A[15:13]==WIN) & (~rd_n | ~wr_n), registered one clock.
REQ-011 FSM states SHALL be IDLE, REQ, ACC, DONE.
REQ-012 IDLE: on shr_hit SHALL latch A[12:0] into shr_addr, cpu_dout into shr_din, wr_n into sub_rnw, assert shr_cs, drop wait_n, go to REQ.
REQ-013 REQ: shr_cs held high; 2-bit counter SHALL count consecutive clocks with mshramen low, reset to 0 on any mshramen high; at count 2 go to ACC.
REQ-014 Main may win contention indefinitely; REQ SHALL keep shr_cs high with no retry limit (unless REQ-024).
REQ-015 ACC: one clock, shr_cs high (write commits here); next state DONE.
REQ-016 DONE entry SHALL capture shr_dout into cpu_din on reads (cpu_din unchanged on writes), deassert shr_cs, raise wait_n.
REQ-017 DONE SHALL remain until mreq_n high, then IDLE; no new request accepted in DONE.
REQ-018 Total latency without contention: shr_hit to wait_n high = 4 clocks.
REQ-019 shr_addr, shr_din, sub_rnw SHALL stay stable from REQ entry through ACC.
REQ-020 Accesses outside the window SHALL leave FSM in IDLE and wait_n high.

Reset
REQ-021 On rst or snd_rstn low: state IDLE, shr_cs 0, wait_n 1, sub_rnw 1, shr_addr 0, shr_din 0, cpu_din 0, counter 0, shr_hit 0.
REQ-022 Reset mid-transaction SHALL abort at once; shr_cs low next clock; no write completes unless ACC already passed.

Configuration
REQ-023 Macro JTKIWI_SHR_TIMEOUT_EN SHALL compile in a watchdog.
REQ-024 With it: 8-bit counter in REQ; at 255 clocks go to DONE with cpu_din=8'hFF, shr_cs low, sticky output timeout_flag (cleared by reset only). Without it: no counter, no timeout_flag port, REQ waits forever.

Structure
REQ-025 State encoding (2-bit enum), WIN default and timeout limit SHALL live in shared package jtkiwi_pkg.
REQ-026 Window decode (REQ-010) MAY be sub-module jtkiwi_shr_dec; FSM stays in jtkiwi_shr_sub.

Verification
REQ-027 Read 0xC123, mshramen=0, shr_dout=0x5A -> shr_addr=0x0123, wait_n high after 4 clocks, cpu_din=0x5A.
REQ-028 Write 0xDFFF data 0x3C, mshramen=0 -> shr_addr=0x1FFF, shr_din=0x3C, sub_rnw=0 through ACC, shr_cs exactly 3 clocks.
REQ-029 mshramen high 10 clocks during REQ -> wait_n low throughout, ACC 2 clocks after mshramen falls, data correct.
REQ-030 snd_rstn low during REQ -> next clock shr_cs=0, wait_n=1, state IDLE.
REQ-031 Access 0xE000 -> shr_cs never asserted, wait_n stays 1.
REQ-032 (JTKIWI_SHR_TIMEOUT_EN) mshramen held high 300 clocks -> cpu_din=0xFF after 255, timeout_flag=1.

Source files
------------

// File: rtl/jtkiwi_pkg.sv
// Shared definitions for the sub-CPU shared-RAM bridge: FSM encoding, window select
// and arbitration/watchdog limits.
package jtkiwi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } shr_st_t;

  // A[15:13] value of the C000-DFFF window
  localparam logic [2:0] SHR_WIN       = 3'b110;
  // consecutive clocks with main off the RAM before the sub-CPU owns it
  localparam logic [1:0] SHR_GRANT_CNT = 2'd2;
  // clocks spent in REQ before the watchdog gives up
  localparam logic [7:0] SHR_TIMEOUT   = 8'd255;

endpackage

// File: rtl/jtkiwi_shr_sub_if.sv
// Sub-CPU bus plus the request port toward main's shared RAM; slave is the bridge side.
interface jtkiwi_shr_sub_if;
  logic [15:0] A;
  logic        mreq_n;
  logic        rfsh_n;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        wait_n;
  logic        shr_hit;
  logic        shr_cs;
  logic [12:0] shr_addr;
  logic [7:0]  shr_din;
  logic        sub_rnw;
  logic [7:0]  shr_dout;
  logic        mshramen;

  modport slave (
    input  A, mreq_n, rfsh_n, rd_n, wr_n, cpu_dout, shr_dout, mshramen,
    output cpu_din, wait_n, shr_hit, shr_cs, shr_addr, shr_din, sub_rnw
  );

  modport master (
    output A, mreq_n, rfsh_n, rd_n, wr_n, cpu_dout, shr_dout, mshramen,
    input  cpu_din, wait_n, shr_hit, shr_cs, shr_addr, shr_din, sub_rnw
  );
endinterface

// File: rtl/jtkiwi_shr_dec.sv
// Shared window decode, registered: 1 clk from strobes to shr_hit.
// No backpressure; refresh and I/O cycles never hit.
module jtkiwi_shr_dec
  import jtkiwi_pkg::*;
#(
  parameter logic [2:0] WIN = SHR_WIN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] a_hi,
  input  logic       mreq_n,
  input  logic       rfsh_n,
  input  logic       rd_n,
  input  logic       wr_n,
  output logic       shr_hit
);

  always_ff @(posedge clk) begin
    if (rst) shr_hit <= 1'b0;
    else     shr_hit <= ~mreq_n & rfsh_n & (a_hi == WIN) & (~rd_n | ~wr_n);
  end

endmodule

// File: rtl/jtkiwi_shr_sub.sv
// Sub-CPU bridge into main's shared RAM; 4 clk from shr_hit to wait_n release when main is idle.
// Holds wait_n low while main owns the RAM; JTKIWI_SHR_TIMEOUT_EN adds a 255-clk watchdog.
module jtkiwi_shr_sub
  import jtkiwi_pkg::*;
#(
  parameter logic [2:0] WIN = SHR_WIN
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic snd_rstn,
`ifdef JTKIWI_SHR_TIMEOUT_EN
  output logic timeout_flag,
`endif
  jtkiwi_shr_sub_if.slave bus
);

  shr_st_t    st;
  logic [1:0] free_cnt;
  logic       srst;
  logic       hit;
  logic       grant;
`ifdef JTKIWI_SHR_TIMEOUT_EN
  logic [7:0] to_cnt;
`endif

  // cen only marks when the CPU samples wait_n; the FSM itself runs on every clk
  logic unused_cen;
  assign unused_cen = cen;

  assign srst        = rst | ~snd_rstn;
  assign bus.shr_hit = hit;
  assign grant       = ~bus.mshramen & (free_cnt == SHR_GRANT_CNT - 2'd1);

  jtkiwi_shr_dec #(.WIN(WIN)) u_dec (
    .clk     (clk),
    .rst     (srst),
    .a_hi    (bus.A[15:13]),
    .mreq_n  (bus.mreq_n),
    .rfsh_n  (bus.rfsh_n),
    .rd_n    (bus.rd_n),
    .wr_n    (bus.wr_n),
    .shr_hit (hit)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      st           <= IDLE;
      bus.shr_cs   <= 1'b0;
      bus.wait_n   <= 1'b1;
      bus.sub_rnw  <= 1'b1;
      bus.shr_addr <= '0;
      bus.shr_din  <= '0;
      bus.cpu_din  <= '0;
      free_cnt     <= '0;
`ifdef JTKIWI_SHR_TIMEOUT_EN
      to_cnt       <= '0;
      timeout_flag <= 1'b0;
`endif
    end else begin
      case (st)
        IDLE: if (hit) begin
          bus.shr_addr <= bus.A[12:0];
          bus.shr_din  <= bus.cpu_dout;
          bus.sub_rnw  <= bus.wr_n;
          bus.shr_cs   <= 1'b1;
          bus.wait_n   <= 1'b0;
          free_cnt     <= '0;
`ifdef JTKIWI_SHR_TIMEOUT_EN
          to_cnt       <= '0;
`endif
          st           <= REQ;
        end
        REQ: begin
          // any clock with main on the RAM restarts the free-run count
          free_cnt <= bus.mshramen ? 2'd0 : free_cnt + 2'd1;
          if (grant) st <= ACC;
`ifdef JTKIWI_SHR_TIMEOUT_EN
          else if (to_cnt == SHR_TIMEOUT - 8'd1) begin
            st           <= DONE;
            bus.shr_cs   <= 1'b0;
            bus.wait_n   <= 1'b1;
            bus.cpu_din  <= 8'hFF;
            timeout_flag <= 1'b1;
          end
          to_cnt <= to_cnt + 8'd1;
`endif
        end
        ACC: begin
          if (bus.sub_rnw) bus.cpu_din <= bus.shr_dout;
          bus.shr_cs <= 1'b0;
          bus.wait_n <= 1'b1;
          st         <= DONE;
        end
        DONE: if (bus.mreq_n) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule
